// File: rtl/pipe_mult_fu.sv
// Pipelined integer multiplier (MUL/MULH/MULHSU/MULHU) with a global stall, flush and tag passthrough.
// Each stage consumes a slice of the multiplier and adds its partial product to a running sum.
module pipe_mult_fu #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned STAGES = 4,
  parameter int unsigned TAG_W  = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             refresh,
  input  logic             val_valid,
  input  logic [XLEN-1:0]  opa,
  input  logic [XLEN-1:0]  opb,
  input  logic [1:0]       func,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             out_ready,
  output logic             in_ready,
  output logic             valid,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] tag_out,
  output logic             busy
);

  localparam int unsigned W2    = 2 * XLEN;
  localparam int unsigned Chunk = W2 / STAGES;
  localparam logic [W2-1:0] ChunkMask = {W2{1'b1}} >> (W2 - Chunk);

  logic [W2-1:0]    s_a   [STAGES];
  logic [W2-1:0]    s_b   [STAGES];
  logic [W2-1:0]    s_acc [STAGES];
  logic [1:0]       s_func[STAGES];
  logic [TAG_W-1:0] s_tag [STAGES];
  logic [STAGES-1:0] s_valid;

  logic          sign_a, sign_b, advance;
  logic [W2-1:0] ext_a, ext_b, final_prod;

  // One stall signal freezes the whole pipe while the output is blocked.
  assign advance  = !(valid && !out_ready);
  assign in_ready = advance;
  assign busy     = (|s_valid) | valid;

  always_comb begin
    sign_a     = (func != 2'b11);
    sign_b     = !func[1];
    ext_a      = {{XLEN{sign_a & opa[XLEN-1]}}, opa};
    ext_b      = {{XLEN{sign_b & opb[XLEN-1]}}, opb};
    final_prod = s_acc[STAGES-1] + s_a[STAGES-1] * (s_b[STAGES-1] & ChunkMask);
  end

  // Datapath carries no reset; the valid bits alone decide what is live.
  always_ff @(posedge clock) begin
    if (advance) begin
      s_a[0]    <= ext_a;
      s_b[0]    <= ext_b;
      s_acc[0]  <= '0;
      s_func[0] <= func;
      s_tag[0]  <= tag_in;
      for (int unsigned i = 1; i < STAGES; i++) begin
        s_a[i]    <= s_a[i-1] << Chunk;
        s_b[i]    <= s_b[i-1] >> Chunk;
        s_acc[i]  <= s_acc[i-1] + s_a[i-1] * (s_b[i-1] & ChunkMask);
        s_func[i] <= s_func[i-1];
        s_tag[i]  <= s_tag[i-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || refresh) begin
      s_valid <= '0;
      valid   <= 1'b0;
      result  <= '0;
      tag_out <= '0;
    end else if (advance) begin
      s_valid[0] <= val_valid;
      for (int unsigned i = 1; i < STAGES; i++) begin
        s_valid[i] <= s_valid[i-1];
      end
      valid <= s_valid[STAGES-1];
      if (s_valid[STAGES-1]) begin
        result  <= (s_func[STAGES-1] == 2'b00) ? final_prod[XLEN-1:0] : final_prod[W2-1:XLEN];
        tag_out <= s_tag[STAGES-1];
      end
    end
  end

endmodule

// File: tb/tb_pipe_mult_fu.sv
// Scoreboard bench for pipe_mult_fu: directed ops push expected results, a monitor pops on handoff.
module tb_pipe_mult_fu;

  logic        clock, reset, refresh, val_valid, out_ready;
  logic [31:0] opa, opb;
  logic [1:0]  func;
  logic [5:0]  tag_in;
  logic        in_ready, valid, busy;
  logic [31:0] result;
  logic [5:0]  tag_out;

  typedef struct {
    logic [31:0] res;
    logic [5:0]  tag;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_pop = 0;
  int   run_len = 0;
  int   max_run = 0;

  localparam logic [1:0] MUL = 2'b00, MULH = 2'b01, MULHSU = 2'b10, MULHU = 2'b11;

  pipe_mult_fu #(.XLEN(32), .STAGES(4), .TAG_W(6)) dut (
    .clock(clock), .reset(reset), .refresh(refresh), .val_valid(val_valid),
    .opa(opa), .opb(opb), .func(func), .tag_in(tag_in), .out_ready(out_ready),
    .in_ready(in_ready), .valid(valid), .result(result), .tag_out(tag_out), .busy(busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: handoff happens on the next posedge whenever valid && out_ready.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      run_len = valid ? run_len + 1 : 0;
      if (run_len > max_run) max_run = run_len;
      if (!reset && valid) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_valid: got valid with tag %0h, expected no output", tag_out);
        end else if (out_ready) begin
          e = q.pop_front();
          chk("mon_result", 64'(result), 64'(e.res));
          chk("mon_tag", 64'(tag_out), 64'(e.tag));
          n_pop++;
        end
      end
    end
  end

  task automatic issue(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] t, input logic [31:0] e);
    int  tries = 0;
    bit  done  = 0;
    val_valid = 1'b1;
    func = f; opa = a; opb = b; tag_in = t;
    while (!done) begin
      @(negedge clock);
      if (in_ready && !refresh && !reset) begin
        q.push_back('{res: e, tag: t});
        done = 1;
      end
      @(posedge clock);
      #1;
      tries++;
      if (!done && tries > 50) begin
        n_cmp++;
        n_err++;
        $display("FAIL issue_timeout: tag %0h not accepted, expected acceptance", t);
        done = 1;
      end
    end
    val_valid = 1'b0;
  endtask

  task automatic drain(input int maxc);
    int c = 0;
    while ((q.size() != 0 || busy) && c < maxc) begin
      @(posedge clock);
      #1;
      c++;
    end
    chk("drain_queue_empty", 64'(q.size()), 64'd0);
    chk("drain_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    int p0;
    reset = 1'b1; refresh = 1'b0; val_valid = 1'b0; out_ready = 1'b1;
    opa = '0; opb = '0; func = '0; tag_in = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_tag", 64'(tag_out), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Latency and single-cycle valid pulse
    max_run = 0;
    issue(MUL, 32'd7, 32'd6, 6'd3, 32'h0000_002A);
    for (int k = 1; k < 4; k++) begin
      @(posedge clock);
      #1;
      chk("lat_valid_low", 64'(valid), 64'd0);
    end
    @(posedge clock);
    #1;
    chk("lat_valid_high", 64'(valid), 64'd1);
    chk("lat_result", 64'(result), 64'h2A);
    chk("lat_tag", 64'(tag_out), 64'd3);
    @(posedge clock);
    #1;
    chk("lat_valid_drop", 64'(valid), 64'd0);
    chk("lat_one_cycle", 64'(max_run), 64'd1);

    // Sign-mode vectors, issued back to back
    issue(MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd1,  32'h0000_0000);
    issue(MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd2,  32'hFFFF_FFFE);
    issue(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd3,  32'hFFFF_FFFF);
    issue(MUL,    32'h8000_0000, 32'h0000_0002, 6'd4,  32'h0000_0000);
    issue(MULH,   32'h8000_0000, 32'h8000_0000, 6'd5,  32'h4000_0000);
    issue(MUL,    32'h1234_5678, 32'h0000_0010, 6'd6,  32'h2345_6780);
    issue(MULHU,  32'h8000_0000, 32'h0000_0004, 6'd7,  32'h0000_0002);
    issue(MULH,   32'hFFFF_FFFE, 32'h0000_0003, 6'd8,  32'hFFFF_FFFF);
    issue(MULHSU, 32'h0000_0002, 32'hFFFF_FFFF, 6'd9,  32'h0000_0001);
    issue(MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd10, 32'h0000_0001);
    drain(40);

    // Throughput: 8 consecutive accepts give 8 consecutive valid cycles
    max_run = 0;
    p0 = n_pop;
    for (int i = 0; i < 8; i++) begin
      issue(MUL, 32'(i + 1), 32'd3, 6'(i), 32'(3 * (i + 1)));
    end
    drain(40);
    chk("tput_run", 64'(max_run), 64'd8);
    chk("tput_count", 64'(n_pop - p0), 64'd8);

    // Stall with a full pipe
    out_ready = 1'b0;
    p0 = n_pop;
    for (int i = 0; i < 5; i++) begin
      issue(MUL, 32'h100 + 32'(i), 32'd2, 6'(20 + i), 32'h200 + 32'(2 * i));
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_valid", 64'(valid), 64'd1);
      chk("stall_result", 64'(result), 64'h200);
      chk("stall_tag", 64'(tag_out), 64'd20);
    end
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    drain(40);
    chk("stall_drained", 64'(n_pop - p0), 64'd5);

    // Refresh squashes in-flight ops and the one presented with it
    p0 = n_pop;
    issue(MUL, 32'd11, 32'd11, 6'd40, 32'd121);
    issue(MUL, 32'd12, 32'd12, 6'd41, 32'd144);
    issue(MUL, 32'd13, 32'd13, 6'd42, 32'd169);
    val_valid = 1'b1; func = MUL; opa = 32'd14; opb = 32'd14; tag_in = 6'd43;
    refresh = 1'b1;
    @(posedge clock);
    #1;
    refresh = 1'b0;
    val_valid = 1'b0;
    q.delete();
    chk("flush_valid", 64'(valid), 64'd0);
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_result", 64'(result), 64'd0);
    issue(MULH, 32'h8000_0000, 32'h8000_0000, 6'd44, 32'h4000_0000);
    drain(40);
    chk("flush_after_count", 64'(n_pop - p0), 64'd1);

    // Reset mid-flight while the output is stalled
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      issue(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'(50 + i), 32'hFFFF_FFFE);
    end
    chk("rmid_valid_before", 64'(valid), 64'd1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    q.delete();
    chk("rmid_valid", 64'(valid), 64'd0);
    chk("rmid_result", 64'(result), 64'd0);
    chk("rmid_tag", 64'(tag_out), 64'd0);
    chk("rmid_busy", 64'(busy), 64'd0);
    chk("rmid_in_ready", 64'(in_ready), 64'd1);
    reset = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    chk("rmid_quiet", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
